// File: rtl/mult_seq_pkg.sv
// Shared definitions for the sequential 8x8 OR-compressed multiplier.
//   OP_W  : operand width
//   NIB_W : nibble width fed to the shared 4x4 unit
//   RES_W : product width
//   MID_W : width of the combined middle partial product (one carry bit)
//   mult_seq_state_t : FSM state encoding, also exported on the debug port
package mult_seq_pkg;
    localparam int OP_W  = 8;
    localparam int NIB_W = 4;
    localparam int RES_W = 16;
    localparam int MID_W = 9;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PP0  = 3'd1,
        PP1  = 3'd2,
        PP2  = 3'd3,
        PP3  = 3'd4,
        DONE = 3'd5
    } mult_seq_state_t;
endpackage

// File: rtl/mult_8x8_orc_seq_mul4.sv
// Shared 4x4 multiplier used by mult_8x8_orc_seq. Exactly one variant is
// compiled, chosen by the macro MULT_SEQ_EXACT_EN:
//   defined   -> mult_4x4_exact : p = a * b
//   undefined -> N2_4x4_mul     : approximate product in which the two
//                                 column-1 partial-product bits are merged
//                                 with OR instead of being added, so the
//                                 carry out of that column is dropped.
// Ports: a [3:0], b [3:0] in; p [7:0] out.
`ifdef MULT_SEQ_EXACT_EN
module mult_4x4_exact (
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [7:0] p
);
    assign p = {4'b0, a} * {4'b0, b};
endmodule
`else
module N2_4x4_mul (
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [7:0] p
);
    logic [7:0] row0;
    logic [7:0] row1;
    logic [7:0] row2;
    logic [7:0] row3;

    always_comb begin
        row0    = {4'b0, a & {4{b[0]}}};
        // Column 1 holds a[1]&b[0] and a[0]&b[1]; OR them into row0 and
        // leave a[0]&b[1] out of row1, which discards their carry.
        row0[1] = (a[1] & b[0]) | (a[0] & b[1]);
        row1    = {3'b0, a[3:1] & {3{b[1]}}, 2'b0};
        row2    = {2'b0, a & {4{b[2]}}, 2'b0};
        row3    = {1'b0, a & {4{b[3]}}, 3'b0};
        p       = row0 + row1 + row2 + row3;
    end
endmodule
`endif

// File: rtl/mult_8x8_orc_seq.sv
// Sequential 8x8 OR-compressed approximate multiplier. One shared 4x4
// multiplier produces the four nibble partial products over four cycles;
// the two middle products are OR-combined (added when MULT_SEQ_EXACT_EN
// is defined, giving an exact A*B reference build).
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high; the producer holds its payload until then. Operands transfer
// on in_valid&in_ready, the result on out_valid&out_ready.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   in_valid/in_ready operand handshake; A, B sampled on accept
//   out_valid/out_ready result handshake; R registered product
//   busy              high whenever the FSM is not in IDLE
//   state             current FSM state (debug visibility)
module mult_8x8_orc_seq
    import mult_seq_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [OP_W-1:0]     A,
    input  logic [OP_W-1:0]     B,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [RES_W-1:0]    R,
    output logic                busy,
    output mult_seq_state_t     state
);
    logic [OP_W-1:0]    a_q;
    logic [OP_W-1:0]    b_q;
    logic [OP_W-1:0]    lo_q;
    logic [MID_W-1:0]   mid_q;
    logic [OP_W-1:0]    hi_q;
    logic [NIB_W-1:0]   mul_a;
    logic [NIB_W-1:0]   mul_b;
    logic [OP_W-1:0]    pp;
    logic [MID_W-1:0]   mid_next;
    logic [RES_W-1:0]   r_next;

    // Nibble select; zero outside PP0..PP3 so the multiplier stays quiet.
    always_comb begin
        mul_a = '0;
        mul_b = '0;
        case (state)
            PP0: begin mul_a = a_q[3:0]; mul_b = b_q[3:0]; end
            PP1: begin mul_a = a_q[3:0]; mul_b = b_q[7:4]; end
            PP2: begin mul_a = a_q[7:4]; mul_b = b_q[3:0]; end
            PP3: begin mul_a = a_q[7:4]; mul_b = b_q[7:4]; end
            default: ;
        endcase
    end

`ifdef MULT_SEQ_EXACT_EN
    mult_4x4_exact u_mul (.a(mul_a), .b(mul_b), .p(pp));
    assign mid_next = mid_q + {1'b0, pp};
`else
    N2_4x4_mul u_mul (.a(mul_a), .b(mul_b), .p(pp));
    assign mid_next = mid_q | {1'b0, pp};
`endif

    // High product sits directly above the low one; the middle term is
    // shifted by one nibble and added on top. Widths sum to 16 bits.
    assign r_next = {pp, lo_q} + {3'b0, mid_q, 4'b0};

    assign in_ready = (state == IDLE);
    assign busy     = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            a_q       <= '0;
            b_q       <= '0;
            lo_q      <= '0;
            mid_q     <= '0;
            hi_q      <= '0;
            R         <= '0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q   <= A;
                        b_q   <= B;
                        lo_q  <= '0;
                        mid_q <= '0;
                        hi_q  <= '0;
                        state <= PP0;
                    end
                end
                PP0: begin
                    lo_q  <= pp;
                    state <= PP1;
                end
                PP1: begin
                    mid_q <= {1'b0, pp};
                    state <= PP2;
                end
                PP2: begin
                    mid_q <= mid_next;
                    state <= PP3;
                end
                PP3: begin
                    hi_q      <= pp;
                    R         <= r_next;
                    out_valid <= 1'b1;
                    state     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mult_8x8_orc_seq.sv
// Self-checking bench for mult_8x8_orc_seq: directed corner operands,
// back-pressure, reset during computation, back-to-back throughput and
// randomized operand pairs against a behavioural product model.
module tb_mult_8x8_orc_seq;
    import mult_seq_pkg::*;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [7:0]      A;
    logic [7:0]      B;
    logic            out_valid;
    logic            out_ready;
    logic [15:0]     R;
    logic            busy;
    mult_seq_state_t state;

    mult_8x8_orc_seq dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B),
        .out_valid(out_valid), .out_ready(out_ready),
        .R(R), .busy(busy), .state(state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard ----------------
    logic [15:0] exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;
    int cur_acc  = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                     tag, obs, obs, exp, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    // Approximate 4x4: the true product, except that when both column-1
    // bits are set (a[1:0]==3 and b[1:0]==3) their carry is lost, costing 2.
    function automatic logic [7:0] mul4(input logic [3:0] a, input logic [3:0] b);
        int p;
        p = int'(a) * int'(b);
`ifndef MULT_SEQ_EXACT_EN
        if (a[1:0] == 2'b11 && b[1:0] == 2'b11) p = p - 2;
`endif
        return p[7:0];
    endfunction

    function automatic logic [15:0] ref_mult(input logic [7:0] a, input logic [7:0] b);
        int r;
`ifdef MULT_SEQ_EXACT_EN
        r = int'(a) * int'(b);
`else
        int p1, p2, p3, p4;
        p1 = int'(mul4(a[3:0], b[3:0]));
        p2 = int'(mul4(a[3:0], b[7:4]));
        p3 = int'(mul4(a[7:4], b[3:0]));
        p4 = int'(mul4(a[7:4], b[7:4]));
        r  = p4 * 256 + p1 + ((p2 | p3) * 16);
`endif
        return r[15:0];
    endfunction

    // ---------------- driver ----------------
    // Called at a negedge with the DUT in IDLE; returns at the negedge
    // after the result handshake, again with the DUT in IDLE.
    // stall = number of cycles out_ready is held low once out_valid rises;
    // during the stall an operand pair is offered and must be ignored.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input int stall);
        int lat;
        logic [15:0] r_hold;
        logic [15:0] exp;
        check_eq("in_ready_idle", in_ready, 1);
        in_valid  = 1'b1;
        A         = a;
        B         = b;
        out_ready = (stall == 0);
        exp_q.push_back(ref_mult(a, b));
        cur_acc   = cyc + 1;
        @(negedge clk);
        in_valid = 1'b0;
        A = 8'($urandom);
        B = 8'($urandom);
        check_eq("busy_after_accept", busy, 1);
        check_eq("in_ready_busy", in_ready, 0);
        lat = 0;
        while (!out_valid && lat < 12) begin
            @(negedge clk);
            lat++;
        end
        check_eq("latency", lat, 4);
        exp = exp_q.pop_front();
        check_eq("product", R, exp);
        r_hold = R;
        for (int i = 0; i < stall; i++) begin
            in_valid = 1'b1;
            A = 8'($urandom);
            B = 8'($urandom);
            @(negedge clk);
            check_eq("stall_r_stable", R, r_hold);
            check_eq("stall_out_valid", out_valid, 1);
            check_eq("stall_in_ready", in_ready, 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check_eq("post_hs_out_valid", out_valid, 0);
        check_eq("post_hs_in_ready", in_ready, 1);
        check_eq("post_hs_r_kept", R, r_hold);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int prev_acc;
        logic [7:0] da [5];
        logic [7:0] db [5];
        da[0] = 8'd200; db[0] = 8'd150;
        da[1] = 8'd255; db[1] = 8'd255;
        da[2] = 8'd0;   db[2] = 8'h9C;
        da[3] = 8'hF0;  db[3] = 8'h0F;
        da[4] = 8'h0F;  db[4] = 8'hF0;

        rst = 1'b1; in_valid = 1'b0; A = '0; B = '0; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_r", R, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_state", state, IDLE);
        rst = 1'b0;

        // directed corners
        for (int i = 0; i < 5; i++) run_op(da[i], db[i], 0);

        // long back-pressure with an ignored operand offer
        run_op(8'h5A, 8'hC3, 10);

        // reset while in PP2
        in_valid = 1'b1; A = 8'hAB; B = 8'hCD; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_eq("mid_state_pp2", state, PP2);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_eq("midrst_state", state, IDLE);
        check_eq("midrst_out_valid", out_valid, 0);
        check_eq("midrst_r", R, 0);
        check_eq("midrst_busy", busy, 0);
        run_op(8'd3, 8'd5, 0);

        // back-to-back: one accept every 6 cycles
        prev_acc = 0;
        for (int i = 0; i < 20; i++) begin
            run_op(8'($urandom), 8'($urandom), 0);
            if (i > 0) check_eq("init_interval", cur_acc - prev_acc, 6);
            prev_acc = cur_acc;
        end

        // randomized pairs with random back-pressure
        for (int i = 0; i < 1000; i++)
            run_op(8'($urandom), 8'($urandom), $urandom_range(0, 2) == 0 ? $urandom_range(1, 3) : 0);

        check_eq("scoreboard_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // global watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got cycle %0d expected completion", cyc);
        $fatal(1, "watchdog");
    end
endmodule
